// File: rtl/add_sub_pkg.sv
// Shared types and op decoding for the pipelined adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } op_e;

    // SUB/SBB add the one's complement of B.
    function automatic logic op_inv(input op_e op);
        return (op == SUB) || (op == SBB);
    endfunction

    function automatic logic op_cin(input op_e op, input logic c_in);
        logic ci;
        case (op)
            ADD:     ci = 1'b0;
            SUB:     ci = 1'b1;
            default: ci = c_in;
        endcase
        return ci;
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module add_sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co       = c[CHUNK];
        c_msb_in = c[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub, one CHUNK-bit ripple segment per stage,
// with a valid/ready stream interface and C/V/N/Z flags.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             C_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             V_out,
    output logic             N_out,
    output logic             Z_out
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    op_e op_s;
    logic adv;

    // Per-stage registers: operands (B already conditionally inverted),
    // partial sum with finished chunks, and the carry out of the stage.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic              v_q, z_q;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [CHUNK-1:0]  s_chunk [STAGES];
    logic [STAGES-1:0] ci_stg;
    logic [STAGES-1:0] co;
    logic              cmsb [STAGES];

    assign op_s     = op_e'(op);
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in[k]   = A;
            assign b_in[k]   = B ^ {WIDTH{op_inv(op_s)}};
            assign s_in[k]   = '0;
            assign ci_stg[k] = op_cin(op_s, C_in);
        end else begin : g_next
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign s_in[k]   = s_q[k-1];
            assign ci_stg[k] = c_q[k-1];
        end

        add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (a_in[k][k*CHUNK +: CHUNK]),
            .b        (b_in[k][k*CHUNK +: CHUNK]),
            .ci       (ci_stg[k]),
            .s        (s_chunk[k]),
            .co       (co[k]),
            .c_msb_in (cmsb[k])
        );

        // Unfinished chunk positions of s_in are always zero, so OR-in is a merge.
        assign s_d[k] = s_in[k] | (WIDTH'(s_chunk[k]) << (k * CHUNK));
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            c_q     <= '0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            c_q     <= co;
            v_q     <= co[LAST] ^ cmsb[LAST];
            z_q     <= (s_d[LAST] == '0);
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign Sum       = s_q[LAST];
    assign C_out     = c_q[LAST];
    assign V_out     = v_q;
    assign N_out     = s_q[LAST][WIDTH-1];
    assign Z_out     = z_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed-vector and scoreboard bench for pipelined_add_sub (8/4 and 16/16).
module tb_pipelined_add_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] A, B, Sum;
    logic [1:0] op;
    logic       C_in, C_out, V_out, N_out, Z_out;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] A1, B1, Sum1;
    logic [1:0]  op1;
    logic        C_in1, C_out1, V_out1, N_out1, Z_out1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       cin;
        logic [7:0] sum;
        logic [3:0] cvnz;
    } vec_t;

    typedef struct packed {
        logic [7:0] sum;
        logic [3:0] cvnz;
    } res_t;

    vec_t vecs[12];
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .C_in(C_in), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(Sum), .C_out(C_out), .V_out(V_out),
        .N_out(N_out), .Z_out(Z_out)
    );

    pipelined_add_sub #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A1), .B(B1), .op(op1), .C_in(C_in1), .out_valid(out_valid1),
        .out_ready(out_ready1), .Sum(Sum1), .C_out(C_out1), .V_out(V_out1),
        .N_out(N_out1), .Z_out(Z_out1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: full-width add with explicit sign-rule overflow.
    function automatic res_t ref_calc(input logic [7:0] a, input logic [7:0] b,
                                      input logic [1:0] o, input logic cin);
        logic [7:0] bx;
        logic       ci;
        logic [8:0] full;
        res_t       r;
        bx     = o[0] ? ~b : b;
        ci     = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bx} + {8'd0, ci};
        r.sum  = full[7:0];
        r.cvnz = {full[8], (a[7] == bx[7]) && (full[7] != a[7]), full[7], full[7:0] == 8'd0};
        return r;
    endfunction

    task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                        input logic cin, input logic [15:0] s, input logic [3:0] f);
        in_valid1 = 1'b1; A1 = a; B1 = b; op1 = o; C_in1 = cin;
        #1;
        chk("w16_ready", in_ready1, 1);
        tick();
        in_valid1 = 1'b0;
        chk("w16_valid", out_valid1, 1);
        chk("w16_sum", Sum1, s);
        chk("w16_flags", {C_out1, V_out1, N_out1, Z_out1}, f);
        tick();
        chk("w16_drained", out_valid1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, got;
        logic fire;
        logic [7:0] bp_exp[3];
        res_t r, act;

        vecs[0]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 4'b0110};
        vecs[1]  = '{8'h05, 8'h05, 2'b01, 1'b0, 8'h00, 4'b1001};
        vecs[2]  = '{8'h00, 8'h01, 2'b01, 1'b0, 8'hFF, 4'b0010};
        vecs[3]  = '{8'hFF, 8'h00, 2'b10, 1'b1, 8'h00, 4'b1001};
        vecs[4]  = '{8'h10, 8'h01, 2'b11, 1'b0, 8'h0E, 4'b1000};
        vecs[5]  = '{8'h80, 8'h80, 2'b00, 1'b0, 8'h00, 4'b1101};
        vecs[6]  = '{8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 4'b1100};
        vecs[7]  = '{8'h0F, 8'h01, 2'b10, 1'b1, 8'h11, 4'b0000};
        vecs[8]  = '{8'h00, 8'h00, 2'b11, 1'b0, 8'hFF, 4'b0010};
        vecs[9]  = '{8'h0F, 8'h01, 2'b00, 1'b1, 8'h10, 4'b0000};
        vecs[10] = '{8'h7F, 8'hFF, 2'b01, 1'b0, 8'h80, 4'b0110};
        vecs[11] = '{8'h7F, 8'h00, 2'b10, 1'b1, 8'h80, 4'b0110};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0; C_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; A1 = '0; B1 = '0; op1 = '0; C_in1 = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_flags", {C_out, V_out, N_out, Z_out}, 0);
        chk("rst_valid16", out_valid1, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1);

        // Single beats with latency and flag checks.
        foreach (vecs[i]) begin
            in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; op = vecs[i].op; C_in = vecs[i].cin;
            #1;
            chk($sformatf("v%0d_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_sum", i), Sum, vecs[i].sum);
            chk($sformatf("v%0d_flags", i), {C_out, V_out, N_out, Z_out}, vecs[i].cvnz);
            tick();
            chk($sformatf("v%0d_once", i), out_valid, 0);
        end

        // Back-pressure: three beats, consumer stalled for 4 cycles once output is valid.
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h04; bp_exp[2] = 8'h06;
        idx = 0; got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (idx < 3);
            A = 8'(idx + 1); B = 8'(idx + 1); op = 2'b00; C_in = 1'b0;
            #1;
            if (cyc >= 2 && cyc < 6) begin
                chk("bp_stall_valid", out_valid, 1);
                chk("bp_stall_ready", in_ready, 0);
                chk("bp_hold_sum", Sum, 8'h02);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", got), Sum, bp_exp[got]);
                got++;
            end
            fire = in_valid && in_ready;
            tick();
            if (fire) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 3);

        // Reset with beats in flight discards them.
        in_valid = 1'b1; A = 8'h11; B = 8'h22; op = 2'b00;
        tick();
        A = 8'h33; B = 8'h44; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", Sum, 0);
        chk("midrst_flags", {C_out, V_out, N_out, Z_out}, 0);
        chk("midrst_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_quiet", out_valid, 0);
        end

        // Random traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = 8'($urandom); B = 8'($urandom);
            op = 2'($urandom_range(0, 3)); C_in = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                act = '{Sum, {C_out, V_out, N_out, Z_out}};
                if (exp_q.size() == 0) chk("rand_extra", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("rand_result", act, r);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_calc(A, B, op, C_in));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (out_valid && exp_q.size() != 0) begin
                act = '{Sum, {C_out, V_out, N_out, Z_out}};
                r = exp_q.pop_front();
                chk("rand_drain", act, r);
            end
            tick();
        end
        chk("rand_left", exp_q.size(), 0);

        // Single-stage configuration: latency 1.
        run1(16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 4'b0110);
        run1(16'h1234, 16'h1234, 2'b01, 1'b0, 16'h0000, 4'b1001);
        run1(16'h0000, 16'h0000, 2'b11, 1'b0, 16'hFFFF, 4'b0010);
        run1(16'hFFFF, 16'h0000, 2'b10, 1'b1, 16'h0000, 4'b1001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
